// File: rtl/fpga_riscv_top_if.sv
// ADAU1761 codec pin bundle: SPI control port plus I2S playback clocks and data.
// Pure wiring with no latency; the codec has no ready signal, so there is no backpressure.
interface fpga_riscv_top_if;
  logic mclk;
  logic clatch;
  logic cdata;
  logic cclk;
  logic dac_sdata;
  logic bclk;
  logic lrclk;

  modport master (output mclk, clatch, cdata, cclk, dac_sdata, bclk, lrclk);
  modport slave  (input  mclk, clatch, cdata, cclk, dac_sdata, bclk, lrclk);
endinterface

// File: rtl/fpga_riscv_top.sv
// Board top: reset and button conditioning, codec SPI init, then an I2S square-wave tone.
// All pin outputs are registered (one cycle); the codec cannot stall, so nothing applies backpressure.
module fpga_riscv_top #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = CLK_HZ / 50,
  parameter int N_INIT          = 8
) (
  input  logic             sys_clk,
  input  logic             btn_c,
  input  logic             btn_u,
  input  logic             btn_d,
  input  logic             btn_l,
  input  logic             btn_r,
  input  logic [7:0]       dip,
  output logic [7:0]       led,
  output logic [7:0]       debug,
  fpga_riscv_top_if.master ac
);

  localparam int IW  = (N_INIT > 1) ? $clog2(N_INIT) : 1;
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {S_RESET, S_LATCH, S_WRITE, S_GAP, S_DONE} state_t;

  logic rst_meta, rst;
  always_ff @(posedge sys_clk) begin
    rst_meta <= btn_c;
    rst      <= rst_meta;
  end

  // One counter feeds every codec clock: bit1 = mclk, bit3 = bclk, bit9 = lrclk.
  logic [9:0] div_cnt;
  always_ff @(posedge sys_clk) begin
    if (rst) div_cnt <= '0;
    else     div_cnt <= div_cnt + 10'd1;
  end

  assign ac.mclk  = div_cnt[1];
  assign ac.bclk  = div_cnt[3];
  assign ac.lrclk = div_cnt[9];

  // Buttons packed in priority order {u, r, d, l}.
  logic [3:0] btn_meta, btn_sync, btn_db;
  logic [DBW-1:0] db_cnt [4];
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      btn_meta <= '0;
      btn_sync <= '0;
      btn_db   <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      btn_meta <= {btn_u, btn_r, btn_d, btn_l};
      btn_sync <= btn_meta;
      for (int i = 0; i < 4; i++) begin
        if (btn_sync[i] == btn_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          btn_db[i] <= btn_sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  // SPI init sequencer
  state_t        state, state_n;
  logic [7:0]    cnt, cnt_n;
  logic [1:0]    pulse, pulse_n;
  logic [IW-1:0] idx, idx_n;
  logic [31:0]   word_n;
  logic          clatch_q, cdata_q, cclk_q;
  logic          clatch_d, cdata_d, cclk_d;
  logic          init_done;

  function automatic logic [23:0] init_rom(input logic [IW-1:0] i);
    case (int'(i))
      0:       init_rom = {16'h4000, 8'h01};
      1:       init_rom = {16'h4015, 8'h01};
      2:       init_rom = {16'h4029, 8'h03};
      3:       init_rom = {16'h402A, 8'h03};
      4:       init_rom = {16'h4023, 8'hE7};
      5:       init_rom = {16'h4024, 8'hE7};
      6:       init_rom = {16'h40F9, 8'h7F};
      7:       init_rom = {16'h40FA, 8'h03};
      default: init_rom = 24'h000000;
    endcase
  endfunction

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= S_RESET;
      cnt      <= '0;
      pulse    <= '0;
      idx      <= '0;
      clatch_q <= 1'b1;
      cdata_q  <= 1'b0;
      cclk_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pulse    <= pulse_n;
      idx      <= idx_n;
      clatch_q <= clatch_d;
      cdata_q  <= cdata_d;
      cclk_q   <= cclk_d;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 8'd1;
    pulse_n = pulse;
    idx_n   = idx;
    case (state)
      S_RESET: begin
        state_n = S_LATCH;
        cnt_n   = '0;
        pulse_n = '0;
        idx_n   = '0;
      end
      S_LATCH: begin
        if (cnt == 8'd15) begin
          cnt_n = '0;
          if (pulse == 2'd2) state_n = S_WRITE;
          else               pulse_n = pulse + 2'd1;
        end
      end
      S_WRITE: begin
        if (cnt == 8'd255) begin
          cnt_n   = '0;
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt == 8'd15) begin
          cnt_n = '0;
          if (idx == IW'(N_INIT - 1)) begin
            state_n = S_DONE;
          end else begin
            idx_n   = idx + IW'(1);
            state_n = S_WRITE;
          end
        end
      end
      S_DONE:  cnt_n = '0;
      default: state_n = S_RESET;
    endcase

    // Pins are derived from the next state so they register in step with it;
    // during a write cnt = {bit[4:0], phase[2:0]} and cclk is phase bit 2.
    word_n   = {8'h00, init_rom(idx_n)};
    clatch_d = !((state_n == S_WRITE) || (state_n == S_LATCH && cnt_n < 8'd8));
    cclk_d   = (state_n == S_WRITE) && cnt_n[2];
    cdata_d  = (state_n == S_WRITE) && word_n[~cnt_n[7:3]];
  end

  assign init_done = (state == S_DONE);
  assign ac.clatch = clatch_q;
  assign ac.cdata  = cdata_q;
  assign ac.cclk   = cclk_q;

  // Tone generator: sign flips every half_frames frames while a button is held.
  logic [6:0]  half_frames, frame_cnt;
  logic        tone_on, tone_neg;
  logic [23:0] amp, sample;
  logic        frame_start;

  always_comb begin
    half_frames = 7'd0;
    if      (btn_db[3]) half_frames = 7'd27;
    else if (btn_db[2]) half_frames = 7'd36;
    else if (btn_db[1]) half_frames = 7'd55;
    else if (btn_db[0]) half_frames = 7'd73;
  end

  assign tone_on     = |btn_db;
  assign amp         = {dip, 16'h0000};
  assign frame_start = (div_cnt == 10'h3FF);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      frame_cnt <= '0;
      tone_neg  <= 1'b0;
      sample    <= '0;
    end else if (frame_start) begin
      if (!tone_on) begin
        frame_cnt <= '0;
        tone_neg  <= 1'b0;
      end else if (frame_cnt >= half_frames - 7'd1) begin
        frame_cnt <= '0;
        tone_neg  <= ~tone_neg;
      end else begin
        frame_cnt <= frame_cnt + 7'd1;
      end
      sample <= (init_done && tone_on) ? (tone_neg ? -amp : amp) : '0;
    end
  end

  // sdata moves with the bclk falling edge; slot bit 0 is the I2S one-bit delay.
  logic [4:0] slot_bit;
  logic       sdata_q;
  assign slot_bit = div_cnt[8:4] + 5'd1;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sdata_q <= 1'b0;
    end else if (div_cnt[3:0] == 4'hF) begin
      if (slot_bit != 5'd0 && slot_bit <= 5'd24) sdata_q <= sample[5'(5'd24 - slot_bit)];
      else                                        sdata_q <= 1'b0;
    end
  end

  assign ac.dac_sdata = sdata_q;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      led   <= '0;
      debug <= '0;
    end else begin
      led   <= init_done ? dip : 8'h00;
      debug <= {init_done, rst, ac.lrclk, ac.bclk, sdata_q, cclk_q, cdata_q, clatch_q};
    end
  end

endmodule

// File: tb/tb_fpga_riscv_top.sv
// Bench for fpga_riscv_top: decodes the SPI and I2S pins and checks them against the codec-level rules.
module tb_fpga_riscv_top;
  localparam int N_INIT = 8;

  logic       sys_clk, btn_c, btn_u, btn_d, btn_l, btn_r;
  logic [7:0] dip, led, debug;

  fpga_riscv_top_if ac();

  fpga_riscv_top #(.CLK_HZ(50_000_000), .DEBOUNCE_CYCLES(4), .N_INIT(N_INIT)) dut (
    .sys_clk (sys_clk),
    .btn_c   (btn_c),
    .btn_u   (btn_u),
    .btn_d   (btn_d),
    .btn_l   (btn_l),
    .btn_r   (btn_r),
    .dip     (dip),
    .led     (led),
    .debug   (debug),
    .ac      (ac)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] rom_model [N_INIT] = '{24'h400001, 24'h401501, 24'h402903, 24'h402A03,
                                      24'h4023E7, 24'h4024E7, 24'h40F97F, 24'h40FA03};

  // SPI decoder: clatch-low runs without clocks are mode-entry pulses, others are writes.
  int          lat_q[$];
  logic [31:0] wr_q[$];
  int          wb_q[$];
  int          spi_low = 0, spi_hi = 0, spi_nbits = 0, min_gap = 1000;
  bit          last_wr = 1'b0;
  logic [31:0] spi_sh = '0;
  logic        p_clatch = 1'b1, p_cclk = 1'b0;

  always @(negedge sys_clk) begin
    if (ac.clatch === 1'b0) begin
      if (p_clatch === 1'b1) begin
        if (last_wr && spi_hi < min_gap) min_gap = spi_hi;
        spi_low = 0;
        spi_nbits = 0;
      end
      spi_low++;
      if (ac.cclk === 1'b1 && p_cclk === 1'b0) begin
        spi_sh = {spi_sh[30:0], ac.cdata};
        spi_nbits++;
      end
    end else if (ac.clatch === 1'b1) begin
      if (p_clatch === 1'b0) begin
        if (spi_nbits == 0) lat_q.push_back(spi_low);
        else begin
          wr_q.push_back(spi_sh);
          wb_q.push_back(spi_nbits);
        end
        last_wr = (spi_nbits != 0);
        spi_hi = 0;
      end
      spi_hi++;
    end
    p_clatch = ac.clatch;
    p_cclk = ac.cclk;
  end

  // I2S decoder: bit 0 after an lrclk change is the delay slot, bits 1..24 the sample.
  logic [24:0] i2s_q[$];
  logic [23:0] i2s_sh = '0;
  int          i2s_idx = 0, pad_err = 0;
  logic        p_bclk = 1'b0, p_lr = 1'bx;

  always @(negedge sys_clk) begin
    if (ac.bclk === 1'b1 && p_bclk === 1'b0) begin
      if (ac.lrclk !== p_lr) i2s_idx = 0;
      else                   i2s_idx++;
      p_lr = ac.lrclk;
      if (i2s_idx >= 1 && i2s_idx <= 24) begin
        i2s_sh = {i2s_sh[22:0], ac.dac_sdata};
        if (i2s_idx == 24) i2s_q.push_back({ac.lrclk, i2s_sh});
      end else if (ac.dac_sdata !== 1'b0) begin
        pad_err++;
      end
    end
    p_bclk = ac.bclk;
  end

  task automatic clear_spi_mon;
    lat_q.delete();
    wr_q.delete();
    wb_q.delete();
    min_gap = 1000;
    last_wr = 1'b0;
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return ac.mclk;
      1:       return ac.bclk;
      default: return ac.lrclk;
    endcase
  endfunction

  // Cycle distances between rise, fall and next rise of one generated clock.
  task automatic measure(input int sel, output int per, output int hi);
    logic prev, cur;
    int t = 0, tr1 = -1, tf = -1, tr2 = -1;
    prev = pick(sel);
    while (tr2 < 0 && t < 4000) begin
      @(negedge sys_clk);
      t++;
      cur = pick(sel);
      if (prev === 1'b0 && cur === 1'b1) begin
        if (tr1 < 0) tr1 = t;
        else if (tf >= 0) tr2 = t;
      end
      if (prev === 1'b1 && cur === 1'b0 && tr1 >= 0 && tf < 0) tf = t;
      prev = cur;
    end
    per = (tr2 >= 0) ? tr2 - tr1 : -1;
    hi  = (tf >= 0) ? tf - tr1 : -1;
  endtask

  task automatic get_frame(output logic [23:0] l, output logic [23:0] r, output bit ok);
    int budget = 3000;
    ok = 1'b0;
    l = 'x;
    r = 'x;
    while (budget > 0) begin
      while (i2s_q.size() > 0 && i2s_q[0][24] !== 1'b0) void'(i2s_q.pop_front());
      if (i2s_q.size() >= 2) begin
        l = i2s_q[0][23:0];
        r = i2s_q[1][23:0];
        ok = (i2s_q[1][24] === 1'b1);
        void'(i2s_q.pop_front());
        void'(i2s_q.pop_front());
        return;
      end
      @(negedge sys_clk);
      budget--;
    end
  endtask

  task automatic test_reset;
    btn_c = 1'b1;
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    n_cmp++; if (led !== 8'h00)        begin n_err++; $display("FAIL reset_led: got %h expected 00", led); end
    n_cmp++; if (debug !== 8'h00)      begin n_err++; $display("FAIL reset_debug: got %h expected 00", debug); end
    n_cmp++; if (ac.clatch !== 1'b1)   begin n_err++; $display("FAIL reset_clatch: got %b expected 1", ac.clatch); end
    n_cmp++; if (ac.cdata !== 1'b0)    begin n_err++; $display("FAIL reset_cdata: got %b expected 0", ac.cdata); end
    n_cmp++; if (ac.cclk !== 1'b0)     begin n_err++; $display("FAIL reset_cclk: got %b expected 0", ac.cclk); end
    n_cmp++; if (ac.dac_sdata !== 1'b0) begin n_err++; $display("FAIL reset_sdata: got %b expected 0", ac.dac_sdata); end
    n_cmp++; if (ac.mclk !== 1'b0)     begin n_err++; $display("FAIL reset_mclk: got %b expected 0", ac.mclk); end
    n_cmp++; if (ac.bclk !== 1'b0)     begin n_err++; $display("FAIL reset_bclk: got %b expected 0", ac.bclk); end
    n_cmp++; if (ac.lrclk !== 1'b0)    begin n_err++; $display("FAIL reset_lrclk: got %b expected 0", ac.lrclk); end
    clear_spi_mon();
    btn_c = 1'b0;
  endtask

  task automatic test_init_seq;
    int budget = 4000;
    while (!(wr_q.size() >= N_INIT && ac.clatch === 1'b1) && budget > 0) begin
      @(negedge sys_clk);
      budget--;
    end
    repeat (40) @(negedge sys_clk);
    n_cmp++; if (budget == 0) begin n_err++; $display("FAIL init_timeout: got %0d writes expected %0d", wr_q.size(), N_INIT); end
    n_cmp++; if (lat_q.size() !== 3) begin n_err++; $display("FAIL latch_pulses: got %0d expected 3", lat_q.size()); end
    foreach (lat_q[i]) begin
      n_cmp++; if (lat_q[i] !== 8) begin n_err++; $display("FAIL latch_len[%0d]: got %0d expected 8", i, lat_q[i]); end
    end
    n_cmp++; if (wr_q.size() !== N_INIT) begin n_err++; $display("FAIL write_count: got %0d expected %0d", wr_q.size(), N_INIT); end
    for (int i = 0; i < wr_q.size() && i < N_INIT; i++) begin
      n_cmp++; if (wr_q[i] !== {8'h00, rom_model[i]}) begin n_err++; $display("FAIL write_word[%0d]: got %h expected %h", i, wr_q[i], {8'h00, rom_model[i]}); end
      n_cmp++; if (wb_q[i] !== 32) begin n_err++; $display("FAIL write_bits[%0d]: got %0d expected 32", i, wb_q[i]); end
    end
    n_cmp++; if (min_gap < 16) begin n_err++; $display("FAIL write_gap: got %0d expected >=16", min_gap); end
    n_cmp++; if (ac.clatch !== 1'b1) begin n_err++; $display("FAIL done_clatch: got %b expected 1", ac.clatch); end
    n_cmp++; if (debug[7] !== 1'b1) begin n_err++; $display("FAIL done_flag: got %b expected 1", debug[7]); end
  endtask

  task automatic test_led;
    for (int k = 0; k < 3; k++) begin
      dip = 8'($urandom_range(1, 255));
      repeat (3) @(negedge sys_clk);
      n_cmp++; if (led !== dip) begin n_err++; $display("FAIL led_dip: got %h expected %h", led, dip); end
    end
  endtask

  task automatic test_clocks;
    int exp_cyc [3] = '{4, 16, 1024};
    int per, hi;
    for (int s = 0; s < 3; s++) begin
      measure(s, per, hi);
      n_cmp++; if (per * 20 !== exp_cyc[s] * 20) begin n_err++; $display("FAIL clk_period[%0d]: got %0d ns expected %0d ns", s, per * 20, exp_cyc[s] * 20); end
      n_cmp++; if (hi * 2 !== exp_cyc[s]) begin n_err++; $display("FAIL clk_duty[%0d]: got high %0d of %0d cycles", s, hi, exp_cyc[s]); end
    end
  endtask

  task automatic test_reset_midwrite;
    int budget = 4000;
    int seen = 0;
    btn_c = 1'b1;
    repeat (5) @(negedge sys_clk);
    clear_spi_mon();
    btn_c = 1'b0;
    while (!(wr_q.size() == 3 && ac.clatch === 1'b0 && spi_nbits >= 4) && budget > 0) begin
      @(negedge sys_clk);
      budget--;
    end
    n_cmp++; if (budget == 0) begin n_err++; $display("FAIL midwrite_reach: got %0d writes expected 3", wr_q.size()); end
    btn_c = 1'b1;
    for (int k = 1; k <= 3 && seen == 0; k++) begin
      @(negedge sys_clk);
      if (ac.clatch === 1'b1) seen = k;
    end
    n_cmp++; if (seen == 0) begin n_err++; $display("FAIL midwrite_clatch: got %b after 3 cycles expected 1", ac.clatch); end
    repeat (5) @(negedge sys_clk);
    n_cmp++; if (ac.cclk !== 1'b0) begin n_err++; $display("FAIL midwrite_cclk: got %b expected 0", ac.cclk); end
    clear_spi_mon();
    btn_c = 1'b0;
    test_init_seq();
  endtask

  task automatic test_tone;
    logic [23:0] a, na, l, r, cur;
    bit ok;
    int run, seg;
    dip = 8'h40;
    a  = 24'h400000;
    na = 24'hC00000;
    btn_u = 1'b1;
    repeat (1100) @(negedge sys_clk);
    i2s_q.delete();
    pad_err = 0;
    get_frame(cur, r, ok);
    run = 1;
    seg = 0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL tone_first_frame: got no frame expected one"); end
    for (int f = 0; f < 80 && seg < 2 && ok; f++) begin
      get_frame(l, r, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL tone_frame_timeout: got none expected frame %0d", f); end
      n_cmp++; if (l !== r) begin n_err++; $display("FAIL tone_lr_equal: got L=%h R=%h", l, r); end
      n_cmp++; if (l !== a && l !== na) begin n_err++; $display("FAIL tone_level: got %h expected %h or %h", l, a, na); end
      if (l === cur) begin
        run++;
      end else begin
        if (seg == 0) begin
          n_cmp++; if (run > 27) begin n_err++; $display("FAIL tone_first_run: got %0d frames expected <=27", run); end
          btn_l = 1'b1;
        end else begin
          n_cmp++; if (run !== 27) begin n_err++; $display("FAIL tone_u_over_l: got %0d frames expected 27", run); end
        end
        seg++;
        cur = l;
        run = 1;
      end
    end
    n_cmp++; if (seg < 2) begin n_err++; $display("FAIL tone_toggles: got %0d expected 2", seg); end
  endtask

  task automatic test_amplitude;
    logic [23:0] amp, l, r;
    bit ok;
    btn_u = 1'b0;
    btn_l = 1'b0;
    btn_d = 1'b1;
    for (int k = 0; k < 2; k++) begin
      dip = (k == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      amp = {dip, 16'h0000};
      repeat (1100) @(negedge sys_clk);
      i2s_q.delete();
      get_frame(l, r, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL amp_timeout: got no frame expected one"); end
      n_cmp++; if (l !== r) begin n_err++; $display("FAIL amp_lr_equal: got L=%h R=%h", l, r); end
      n_cmp++; if (l !== amp && l !== 24'(-amp)) begin n_err++; $display("FAIL amp_level: got %h expected +-%h", l, amp); end
    end
  endtask

  task automatic test_release;
    logic [23:0] l, r;
    bit ok;
    dip = 8'($urandom_range(1, 255));
    btn_u = 1'b0;
    btn_d = 1'b0;
    btn_l = 1'b0;
    btn_r = 1'b0;
    repeat (1100) @(negedge sys_clk);
    i2s_q.delete();
    for (int k = 0; k < 2; k++) begin
      get_frame(l, r, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL release_timeout: got no frame expected one"); end
      n_cmp++; if (l !== 24'h0 || r !== 24'h0) begin n_err++; $display("FAIL release_silent: got L=%h R=%h expected 0", l, r); end
    end
    n_cmp++; if (pad_err !== 0) begin n_err++; $display("FAIL i2s_pad_bits: got %0d nonzero expected 0", pad_err); end
  endtask

  initial begin
    btn_c = 1'b1;
    btn_u = 1'b0;
    btn_d = 1'b0;
    btn_l = 1'b0;
    btn_r = 1'b0;
    dip   = 8'h00;
    test_reset();
    test_init_seq();
    test_led();
    test_clocks();
    test_reset_midwrite();
    test_tone();
    test_amplitude();
    test_release();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
